// File: rtl/moo_mac_tag_if.sv
// moo_mac_tag op request channel.
// Carries context/op select with a valid/ready handshake.
interface moo_mac_tag_if #(
  parameter int CTX_W = 1
);
  logic [CTX_W-1:0] mac_ctx;
  logic [2:0]       mac_op;
  logic             mac_valid;
  logic             mac_ready;

  modport master (
    output mac_ctx, mac_op, mac_valid,
    input  mac_ready
  );

  modport slave (
    input  mac_ctx, mac_op, mac_valid,
    output mac_ready
  );
endinterface

// File: rtl/moo_mac_tag.sv
// Multi-context MAC accumulator, CMAC subkeys and tag unit.
// Define MOO_MAC_TAG_CMP_EN to build the reference tag comparator.
module moo_mac_tag #(
  parameter int          NUM_CTX  = 2,
  parameter int          CTX_W    = 1,
  parameter logic [7:0]  RB_CONST = 8'h87
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_core,
  moo_mac_tag_if.slave        bus,
  input  logic [127:0]        ecb_do,
  input  logic [127:0]        ghash,
  input  logic [3:0]          size_msg,
  input  logic [4:0]          tag_len,
  input  logic [127:0]        tag_ref,
  output logic [127:0]        mac_do,
  output logic [127:0]        tag_out,
  output logic                tag_valid,
  output logic                tag_match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SK2  = 2'd1,
    CMP  = 2'd2
  } state_t;

  localparam logic [CTX_W:0] NCTX = (CTX_W+1)'(NUM_CTX);

  function automatic logic [127:0] dbl(input logic [127:0] x);
    return {x[126:0], 1'b0} ^
           (x[127] ? {120'd0, RB_CONST} : 128'd0);
  endfunction

  function automatic logic [127:0] tmask(input logic [4:0] n);
    logic [4:0] b;
    b = (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
    return ~({128{1'b1}} >> {b, 3'b000});
  endfunction

  state_t              state, state_nx;
  logic [127:0]        acc [NUM_CTX];
  logic [127:0]        k1  [NUM_CTX];
  logic [127:0]        k2  [NUM_CTX];
  logic [CTX_W-1:0]    ctx_q;
  logic [NUM_CTX-1:0]  hit;
  logic [127:0]        k1_sel, k2_sel;
  logic [127:0]        acc_nx;
  logic                acc_we, k1_we, fin;
  logic                ctx_ok, accept;
  logic                sk_go, fin_go;

  assign ctx_ok        = {1'b0, bus.mac_ctx} < NCTX;
  assign bus.mac_ready = (state == IDLE);
  assign accept        = bus.mac_valid & bus.mac_ready & ctx_ok;
  assign sk_go         = accept & k1_we;
  assign fin_go        = accept & fin;

  always_comb begin
    mac_do = '0;
    k1_sel = '0;
    k2_sel = '0;
    hit    = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (CTX_W'(i) == bus.mac_ctx) begin
        hit[i] = 1'b1;
        mac_do = acc[i];
        k1_sel = k1[i];
        k2_sel = k2[i];
      end
    end
  end

  always_comb begin
    acc_we = 1'b0;
    acc_nx = mac_do;
    k1_we  = 1'b0;
    fin    = 1'b0;
    unique case (1'b1)
      bus.mac_op == 3'b000: begin
        acc_we = 1'b1;
        acc_nx = ecb_do;
      end
      bus.mac_op == 3'b001: k1_we = 1'b1;
      bus.mac_op == 3'b010: begin
        acc_we = 1'b1;
        acc_nx = (size_msg == 4'd0) ? k1_sel : k2_sel;
      end
      bus.mac_op == 3'b011: begin
        acc_we = 1'b1;
        acc_nx = mac_do ^ ecb_do;
      end
      bus.mac_op == 3'b100: begin
        acc_we = 1'b1;
        acc_nx = mac_do ^ ghash;
      end
      bus.mac_op == 3'b101: begin
        acc_we = 1'b1;
        acc_nx = '0;
      end
      bus.mac_op == 3'b110: fin = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (sk_go)       state_nx = SK2;
        else if (fin_go) state_nx = CMP;
      end
      SK2:     state_nx = IDLE;
      CMP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctx_q <= '0;
    end else if (clr_core) begin
      state <= IDLE;
      ctx_q <= '0;
    end else begin
      state <= state_nx;
      if (sk_go) ctx_q <= bus.mac_ctx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        acc[i] <= '0;
        k1[i]  <= '0;
        k2[i]  <= '0;
      end
    end else if (clr_core) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        acc[i] <= '0;
        k1[i]  <= '0;
        k2[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (accept && hit[i] && acc_we) acc[i] <= acc_nx;
        if (sk_go && hit[i]) k1[i] <= dbl(ecb_do);
        // second doubling runs from the k1 written last cycle
        if (state == SK2 && ctx_q == CTX_W'(i))
          k2[i] <= dbl(k1[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_out   <= '0;
      tag_valid <= 1'b0;
    end else if (clr_core) begin
      tag_out   <= '0;
      tag_valid <= 1'b0;
    end else begin
      tag_valid <= (state == CMP);
      if (fin_go) tag_out <= mac_do & tmask(tag_len);
    end
  end

`ifdef MOO_MAC_TAG_CMP_EN
  logic [127:0] ref_q;
  logic         match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q   <= '0;
      match_q <= 1'b0;
    end else if (clr_core) begin
      ref_q   <= '0;
      match_q <= 1'b0;
    end else begin
      if (fin_go) ref_q <= tag_ref & tmask(tag_len);
      if (state == CMP) match_q <= (tag_out == ref_q);
    end
  end

  assign tag_match = match_q;
`else
  logic unused_tag_ref;

  assign unused_tag_ref = ^tag_ref;
  assign tag_match      = 1'b0;
`endif

endmodule

// File: tb/tb_moo_mac_tag.sv
// Scoreboard bench for moo_mac_tag.
// Random ops checked against an array/queue reference model.
module tb_moo_mac_tag;
  localparam int NUM_CTX = 2;
  localparam int CTX_W   = 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SK   = 3'b001;
  localparam logic [2:0] OP_CK   = 3'b010;
  localparam logic [2:0] OP_CCM  = 3'b011;
  localparam logic [2:0] OP_GCM  = 3'b100;
  localparam logic [2:0] OP_FIN  = 3'b110;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_core = 1'b0;
  logic [127:0] ecb_do = '0;
  logic [127:0] ghash = '0;
  logic [3:0]   size_msg = '0;
  logic [4:0]   tag_len = '0;
  logic [127:0] tag_ref = '0;
  logic [127:0] mac_do;
  logic [127:0] tag_out;
  logic         tag_valid;
  logic         tag_match;

  moo_mac_tag_if #(.CTX_W(CTX_W)) bus ();

  moo_mac_tag #(
    .NUM_CTX (NUM_CTX),
    .CTX_W   (CTX_W),
    .RB_CONST(8'h87)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_core (clr_core),
    .bus      (bus),
    .ecb_do   (ecb_do),
    .ghash    (ghash),
    .size_msg (size_msg),
    .tag_len  (tag_len),
    .tag_ref  (tag_ref),
    .mac_do   (mac_do),
    .tag_out  (tag_out),
    .tag_valid(tag_valid),
    .tag_match(tag_match)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    logic [127:0] tag;
    logic         match;
    int           due;
  } exp_t;
  exp_t q[$];

  logic [127:0] m_acc [NUM_CTX];
  logic [127:0] m_k1  [NUM_CTX];
  logic [127:0] m_k2  [NUM_CTX];
  logic [127:0] m_tag, m_ref;
  logic         m_match;
  int           m_busy;
  int           m_sk_ctx;
  bit           m_sk_pend, m_fin_pend;

  function automatic logic [127:0] gf_dbl(input logic [127:0] x);
    return (x << 1) ^ (x[127] ? 128'h87 : 128'h0);
  endfunction

  function automatic logic [127:0] keep_bytes(input logic [4:0] n);
    logic [127:0] m;
    int nb;
    m  = '0;
    nb = (n == 0 || n > 16) ? 16 : int'(n);
    for (int i = 0; i < 16; i++)
      if (i < nb) m[127-8*i -: 8] = 8'hff;
    return m;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CTX; i++) begin
      m_acc[i] = '0;
      m_k1[i]  = '0;
      m_k2[i]  = '0;
    end
    m_tag      = '0;
    m_ref      = '0;
    m_match    = 1'b0;
    m_busy     = 0;
    m_sk_pend  = 0;
    m_fin_pend = 0;
  endtask

  task automatic step(input bit v, input logic [2:0] op,
                      input int c, input logic [127:0] e,
                      input logic [127:0] g, input logic [3:0] sz,
                      input logic [4:0] tl, input logic [127:0] tr,
                      input bit clr);
    bit take;
    bus.mac_valid = v;
    bus.mac_op    = op;
    bus.mac_ctx   = c[CTX_W-1:0];
    ecb_do        = e;
    ghash         = g;
    size_msg      = sz;
    tag_len       = tl;
    tag_ref       = tr;
    clr_core      = clr;
    chk("mac_ready", {127'd0, bus.mac_ready},
        {127'd0, m_busy == 0});
    take = v && (m_busy == 0);
    @(posedge clk);
    #1;
    if (clr) begin
      model_clear();
    end else begin
      if (m_sk_pend) m_k2[m_sk_ctx] = gf_dbl(m_k1[m_sk_ctx]);
      if (m_fin_pend) begin
`ifdef MOO_MAC_TAG_CMP_EN
        m_match = (m_tag == m_ref);
`else
        m_match = 1'b0;
`endif
        q.push_back('{m_tag, m_match, cyc});
      end
      m_sk_pend  = 0;
      m_fin_pend = 0;
      m_busy     = 0;
      if (take) begin
        case (op)
          3'b000: m_acc[c] = e;
          3'b001: begin
            m_k1[c]   = gf_dbl(e);
            m_sk_ctx  = c;
            m_sk_pend = 1;
            m_busy    = 1;
          end
          3'b010: m_acc[c] = (sz == 0) ? m_k1[c] : m_k2[c];
          3'b011: m_acc[c] = m_acc[c] ^ e;
          3'b100: m_acc[c] = m_acc[c] ^ g;
          3'b101: m_acc[c] = '0;
          3'b110: begin
            m_tag      = m_acc[c] & keep_bytes(tl);
            m_ref      = tr & keep_bytes(tl);
            m_fin_pend = 1;
            m_busy     = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic op(input logic [2:0] o, input int c,
                    input logic [127:0] e);
    step(1, o, c, e, '0, 4'd0, 5'd16, '0, 0);
  endtask

  task automatic idle(input int c);
    step(0, 3'b000, c, '0, '0, 4'd0, 5'd0, '0, 0);
  endtask

  task automatic fin(input int c, input logic [4:0] tl,
                     input logic [127:0] tr);
    step(1, OP_FIN, c, '0, '0, 4'd0, tl, tr, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t x;
      chk("mac_do", mac_do, m_acc[bus.mac_ctx]);
      chk("tag_out_hold", tag_out, m_tag);
      chk("tag_match_hold", {127'd0, tag_match}, {127'd0, m_match});
      if (tag_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tag_valid_spurious actual=1 required=0 cyc=%0d",
                   cyc);
        end else begin
          x = q.pop_front();
          chk("tag_val", tag_out, x.tag);
          chk("tag_match", {127'd0, tag_match}, {127'd0, x.match});
          chk("tag_cycle", 128'(cyc), 128'(x.due));
        end
      end else if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        errors++;
        $display("FAIL tag_valid_missing actual=0 required=1 cyc=%0d",
                 x.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] SK_IN = 128'h7df76b0c1ab899b33e42f047b91b546f;
  localparam logic [127:0] K1    = 128'hfbeed618357133667c85e08f7236a8de;
  localparam logic [127:0] K2    = 128'hf7ddac306ae266ccf90bc11ee46d513b;
  localparam logic [127:0] MV    = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] a, b, c3;
    bus.mac_valid = 1'b0;
    bus.mac_op    = 3'b000;
    bus.mac_ctx   = '0;
    model_clear();

    #12;
    for (int i = 0; i < NUM_CTX; i++) begin
      bus.mac_ctx = i[CTX_W-1:0];
      #1;
      chk("rst_mac_do", mac_do, '0);
    end
    chk("rst_tag_out", tag_out, '0);
    chk("rst_tag_valid", {127'd0, tag_valid}, '0);
    chk("rst_ready", {127'd0, bus.mac_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    op(OP_SK, 0, SK_IN);
    idle(0);
    step(1, OP_CK, 0, '0, '0, 4'd0, 5'd0, '0, 0);
    chk("k1_vec", mac_do, K1);
    step(1, OP_CK, 0, '0, '0, 4'd5, 5'd0, '0, 0);
    chk("k2_vec", mac_do, K2);

    a  = rnd128();
    b  = rnd128();
    c3 = rnd128();
    op(OP_LOAD, 1, a);
    op(OP_CCM, 1, b);
    step(1, OP_GCM, 1, '0, c3, 4'd0, 5'd0, '0, 0);
    chk("abc", mac_do, a ^ b ^ c3);
    idle(0);
    chk("ctx0_kept", mac_do, K2);

    op(OP_LOAD, 0, MV);
    fin(0, 5'd4, 128'h00112233ffffffffffffffffffffffff);
    idle(0);
    idle(0);
    chk("tag4", tag_out, 128'h00112233000000000000000000000000);
    fin(0, 5'd4, 128'h00112234000000000000000000000000);
    idle(0);
    idle(0);
    fin(0, 5'd0, MV);
    idle(0);
    idle(0);
    chk("tag_len0", tag_out, MV);
    fin(0, 5'd20, '0);
    idle(0);
    idle(0);
    chk("tag_len20", tag_out, MV);

    fin(0, 5'd16, MV);
    op(OP_LOAD, 0, rnd128());
    idle(0);
    chk("busy_ignored", mac_do, MV);

    fin(0, 5'd16, MV);
    step(0, 3'b000, 0, '0, '0, 4'd0, 5'd0, '0, 1);
    idle(0);
    idle(0);
    chk("clr_cmp_tag", tag_out, '0);
    chk("clr_cmp_acc", mac_do, '0);

    op(OP_SK, 1, SK_IN);
    step(0, 3'b000, 1, '0, '0, 4'd0, 5'd0, '0, 1);
    step(1, OP_CK, 1, '0, '0, 4'd0, 5'd0, '0, 0);
    chk("clr_sk_k1", mac_do, '0);
    step(1, OP_CK, 1, '0, '0, 4'd3, 5'd0, '0, 0);
    chk("clr_sk_k2", mac_do, '0);

    op(OP_LOAD, 0, rnd128());
    step(0, 3'b000, 0, '0, '0, 4'd0, 5'd0, '0, 1);
    step(1, OP_CCM, 0, rnd128(), '0, 4'd0, 5'd0, '0, 1);
    chk("clr_ccm", mac_do, '0);

    for (int n = 0; n < 400; n++) begin
      int           rc;
      logic [127:0] tr;
      rc = $urandom_range(0, NUM_CTX - 1);
      tr = ($urandom_range(0, 1) == 1) ? m_acc[rc] : rnd128();
      step($urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), rc,
           rnd128(), rnd128(),
           4'($urandom_range(0, 15)),
           5'($urandom_range(0, 31)), tr,
           $urandom_range(0, 39) == 0);
    end

    for (int n = 0; n < 4; n++) idle(0);
    @(negedge clk);
    mon_en = 0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
